// File: rtl/fpu_op_scheduler.sv
// ============================================================================
// Module      : fpu_op_scheduler
// Description : Request/response sequencer for the single-precision add/sub,
//               multiply and iterative divide units, with divide bypass for
//               NaN / zero-divisor cases and a divider timeout guard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_op_scheduler #(
    parameter int DIV_TIMEOUT = 64,
    parameter int CNT_W       = $clog2(DIV_TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [31:0]       in1,
    input  logic [31:0]       in2,
    output logic [31:0]       unit_a,
    output logic [31:0]       unit_b,
    output logic              addsub_sub,
    input  logic [31:0]       addsub_result,
    input  logic [31:0]       mul_result,
    output logic              div_start,
    input  logic              div_done,
    input  logic [31:0]       div_result,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       result,
    output logic              busy,
    output logic              timeout_err
);

    localparam logic [1:0]       OP_ADD   = 2'b00;
    localparam logic [1:0]       OP_SUB   = 2'b01;
    localparam logic [1:0]       OP_MUL   = 2'b10;
    localparam logic [1:0]       OP_DIV   = 2'b11;
    localparam logic [31:0]      QNAN     = 32'h7FFF_FFFF;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t           state;
    logic [1:0]       op;
    logic [CNT_W-1:0] cnt;

    function automatic logic f_is_nan(input logic [31:0] x);
        return (&x[30:23]) && (|x[22:0]);
    endfunction

    function automatic logic f_is_zero(input logic [31:0] x);
        return ~|x[30:0];
    endfunction

    function automatic logic f_div_bypass(input logic [31:0] a, input logic [31:0] b);
        return f_is_nan(a) || f_is_nan(b) || f_is_zero(b);
    endfunction

    // Result for a bypassed divide, in priority order: NaN, 0/0, x/0.
    function automatic logic [31:0] f_bypass_value(input logic [31:0] a, input logic [31:0] b);
        if (f_is_nan(a) || f_is_nan(b)) begin
            return QNAN;
        end else if (f_is_zero(a) && f_is_zero(b)) begin
            return QNAN;
        end else begin
            return {a[31] ^ b[31], 31'h7F80_0000};
        end
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            op          <= OP_ADD;
            cnt         <= '0;
            unit_a      <= '0;
            unit_b      <= '0;
            addsub_sub  <= 1'b0;
            div_start   <= 1'b0;
            result      <= '0;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            div_start   <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        unit_a     <= in1;
                        unit_b     <= in2;
                        op         <= req_op;
                        addsub_sub <= (req_op == OP_SUB);
                        // The start pulse is registered at accept so the
                        // divider sees it while the scheduler is in EXEC;
                        // in1/in2 equal the operands being latched.
                        div_start  <= (req_op == OP_DIV) && !f_div_bypass(in1, in2);
                        req_ready  <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    case (op)
                        OP_ADD, OP_SUB: begin
                            result     <= addsub_result;
                            resp_valid <= 1'b1;
                            state      <= S_RESP;
                        end
                        OP_MUL: begin
                            result     <= mul_result;
                            resp_valid <= 1'b1;
                            state      <= S_RESP;
                        end
                        default: begin
                            if (f_div_bypass(unit_a, unit_b)) begin
                                result     <= f_bypass_value(unit_a, unit_b);
                                resp_valid <= 1'b1;
                                state      <= S_RESP;
                            end else begin
                                cnt   <= '0;
                                state <= S_WAIT;
                            end
                        end
                    endcase
                end

                S_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    // A done arriving on the last allowed cycle beats the timeout.
                    if (div_done) begin
                        result     <= div_result;
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                    end else if (cnt == CNT_LAST) begin
                        result      <= QNAN;
                        timeout_err <= 1'b1;
                        resp_valid  <= 1'b1;
                        state       <= S_RESP;
                    end
                end

                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end
                end

                default: begin
                    state      <= S_IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fpu_op_scheduler.sv
// ============================================================================
// Module      : tb_fpu_op_scheduler
// Description : Directed vector bench for fpu_op_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpu_op_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] unit_a;
    logic [31:0] unit_b;
    logic        addsub_sub;
    logic [31:0] addsub_result;
    logic [31:0] mul_result;
    logic        div_start;
    logic        div_done;
    logic [31:0] div_result;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] result;
    logic        busy;
    logic        timeout_err;

    int n_vec = 0;
    int n_err = 0;

    fpu_op_scheduler #(.DIV_TIMEOUT(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .in1           (in1),
        .in2           (in2),
        .unit_a        (unit_a),
        .unit_b        (unit_b),
        .addsub_sub    (addsub_sub),
        .addsub_result (addsub_result),
        .mul_result    (mul_result),
        .div_start     (div_start),
        .div_done      (div_done),
        .div_result    (div_result),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .result        (result),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] as_res;
        logic [31:0] mul_res;
        logic [31:0] div_res;
        int          delay;     // divider done delay after start, -1 = never
        int          hold;      // cycles resp_ready is held low
        logic [31:0] exp_res;
        int          exp_lat;
        int          exp_start;
        int          exp_to;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int   start_cyc;
        int   starts;
        int   tos;
        int   rr_hi;
        int   lat;
        bit   got;
        logic [31:0] res;
        start_cyc = -1;
        starts    = 0;
        tos       = 0;
        rr_hi     = 0;
        lat       = -1;
        got       = 1'b0;
        res       = '0;

        @(negedge clk);
        chk("idle_req_ready", req_ready, 32'd1);
        req_valid     = 1'b1;
        req_op        = v.op;
        in1           = v.a;
        in2           = v.b;
        addsub_result = v.as_res;
        mul_result    = v.mul_res;
        div_result    = v.div_res;
        resp_ready    = (v.hold == 0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        in1       = ~v.a;
        in2       = ~v.b;

        for (int cyc = 1; cyc <= 100 && !got; cyc++) begin
            if (div_start) begin
                starts++;
                if (start_cyc < 0) start_cyc = cyc;
            end
            if (timeout_err) tos++;
            if (req_ready) rr_hi++;
            if (resp_valid) begin
                got = 1'b1;
                lat = cyc;
                res = result;
            end else begin
                div_done = (start_cyc >= 0) && (v.delay >= 0) && (cyc == start_cyc + v.delay);
                @(posedge clk);
                @(negedge clk);
                div_done = 1'b0;
            end
        end

        chk("resp_seen", 32'(got), 32'd1);
        if (!got) begin
            pulse_reset();
            return;
        end
        chk("result", res, v.exp_res);
        chk("latency", lat, v.exp_lat);
        chk("div_start_pulses", starts, v.exp_start);
        chk("timeout_pulses", tos, v.exp_to);
        chk("req_ready_low_busy", rr_hi, 32'd0);
        chk("addsub_sub", addsub_sub, 32'(v.op == 2'b01));
        chk("unit_a", unit_a, v.a);
        chk("unit_b", unit_b, v.b);

        for (int h = 0; h < v.hold; h++) begin
            chk("hold_valid", resp_valid, 32'd1);
            chk("hold_result", result, v.exp_res);
            @(posedge clk);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_req_ready", req_ready, 32'd1);
        chk("post_resp_valid", resp_valid, 32'd0);
        chk("post_busy", busy, 32'd0);
        chk("post_timeout_err", timeout_err, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t mul_after;

        //          op     a             b             as_res        mul_res       div_res       dly hold exp_res     lat st to
        vecs[0]  = '{2'b00, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h0,        32'h0,        -1, 0, 32'h40400000, 2, 0, 0};
        vecs[1]  = '{2'b01, 32'h40400000, 32'h3F800000, 32'h40000000, 32'h0,        32'h0,        -1, 5, 32'h40000000, 2, 0, 0};
        vecs[2]  = '{2'b10, 32'h40000000, 32'h40400000, 32'h11111111, 32'h40C00000, 32'h0,        -1, 0, 32'h40C00000, 2, 0, 0};
        vecs[3]  = '{2'b11, 32'h40C00000, 32'h40000000, 32'h0,        32'h0,        32'h40400000, 10, 0, 32'h40400000, 12, 1, 0};
        vecs[4]  = '{2'b11, 32'h3F800000, 32'h80000000, 32'h0,        32'h0,        32'h12345678, 10, 0, 32'hFF800000, 2, 0, 0};
        vecs[5]  = '{2'b11, 32'h00000000, 32'h00000000, 32'h0,        32'h0,        32'h12345678, 10, 0, 32'h7FFFFFFF, 2, 0, 0};
        vecs[6]  = '{2'b11, 32'h7FC00000, 32'h3F800000, 32'h0,        32'h0,        32'h12345678, 10, 0, 32'h7FFFFFFF, 2, 0, 0};
        vecs[7]  = '{2'b11, 32'h80000000, 32'hFFC00000, 32'h0,        32'h0,        32'h12345678, 10, 0, 32'h7FFFFFFF, 2, 0, 0};
        vecs[8]  = '{2'b11, 32'h80000001, 32'h00000000, 32'h0,        32'h0,        32'h12345678, 10, 0, 32'hFF800000, 2, 0, 0};
        vecs[9]  = '{2'b11, 32'h3F800000, 32'h40000000, 32'h0,        32'h0,        32'h12345678, -1, 0, 32'h7FFFFFFF, 66, 1, 1};
        vecs[10] = '{2'b11, 32'h3F800000, 32'h40000000, 32'h0,        32'h0,        32'h3F000000, 64, 0, 32'h3F000000, 66, 1, 0};
        vecs[11] = '{2'b11, 32'h40000000, 32'h40800000, 32'h0,        32'h0,        32'h3F000000, 63, 2, 32'h3F000000, 65, 1, 0};
        mul_after = '{2'b10, 32'h40400000, 32'h40400000, 32'h0,        32'h41100000, 32'hDEADBEEF, -1, 0, 32'h41100000, 2, 0, 0};

        rst           = 1'b1;
        req_valid     = 1'b0;
        req_op        = 2'b00;
        in1           = '0;
        in2           = '0;
        addsub_result = '0;
        mul_result    = '0;
        div_done      = 1'b0;
        div_result    = '0;
        resp_ready    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk("rst_req_ready", req_ready, 32'd1);
        chk("rst_resp_valid", resp_valid, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_div_start", div_start, 32'd0);
        chk("rst_timeout_err", timeout_err, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_unit_a", unit_a, 32'd0);
        chk("rst_unit_b", unit_b, 32'd0);
        chk("rst_addsub_sub", addsub_sub, 32'd0);

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i]);
        end

        // Reset while the divider is outstanding, then a stray late done.
        @(negedge clk);
        req_valid  = 1'b1;
        req_op     = 2'b11;
        in1        = 32'h3F800000;
        in2        = 32'h40000000;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("wait_busy", busy, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 32'd0);
        chk("abort_req_ready", req_ready, 32'd1);
        chk("abort_resp_valid", resp_valid, 32'd0);
        chk("abort_div_start", div_start, 32'd0);
        div_result = 32'hDEADBEEF;
        div_done   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        div_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stray_resp_valid", resp_valid, 32'd0);
            chk("stray_busy", busy, 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        run_vec(mul_after);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
